// File: rtl/iq_drain_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_drain_pkg : shared sizes, drain state type and lane-count helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`ifndef instrQ_width
`define instrQ_width 16
`endif

package iq_drain_pkg;

  localparam int IQ_RD_SLOTS = 11;
  localparam int IQ_WIDTH    = 80;
  localparam int IQ_OTHER    = `instrQ_width;
  localparam int IQ_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } drain_state_t;

  function automatic logic [IQ_CNT_W-1:0] popcnt(input logic [IQ_RD_SLOTS-1:0] v);
    logic [IQ_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IQ_RD_SLOTS; i++) c = c + IQ_CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [IQ_RD_SLOTS-1:0] therm(input logic [IQ_CNT_W-1:0] n);
    logic [IQ_RD_SLOTS-1:0] t;
    for (int i = 0; i < IQ_RD_SLOTS; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  function automatic logic [IQ_CNT_W-1:0] min3(input logic [IQ_CNT_W-1:0] a,
                                               input logic [IQ_CNT_W-1:0] b,
                                               input logic [IQ_CNT_W-1:0] c);
    logic [IQ_CNT_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_drain_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_drain_if : queue read port plus downstream bundle handshake
// Rev 1.0
// ----------------------------------------------------------------------------
interface iq_drain_if
  import iq_drain_pkg::*;
#(
  parameter int RD_SLOTS = IQ_RD_SLOTS,
  parameter int WIDTH    = IQ_WIDTH,
  parameter int OTHER    = IQ_OTHER
);

  logic                      q_read_thread;
  logic                      q_read_clkEn;
  logic [RD_SLOTS-1:0]       q_read_instrEn;
  logic [RD_SLOTS-1:0]       q_read_avail;
  logic [RD_SLOTS*WIDTH-1:0] q_read_instr0;
  logic [RD_SLOTS*OTHER-1:0] q_read_other0;

  logic [IQ_CNT_W-1:0]       dn_max;
  logic                      dn_ready;
  logic                      dn_valid;
  logic                      dn_thread;
  logic [RD_SLOTS-1:0]       dn_instrEn;
  logic [RD_SLOTS*WIDTH-1:0] dn_instr;
  logic [RD_SLOTS*OTHER-1:0] dn_other;

  modport master (
    output q_read_thread, q_read_clkEn, q_read_instrEn,
    output dn_valid, dn_thread, dn_instrEn, dn_instr, dn_other,
    input  q_read_avail, q_read_instr0, q_read_other0, dn_max, dn_ready
  );

  modport slave (
    input  q_read_thread, q_read_clkEn, q_read_instrEn,
    input  dn_valid, dn_thread, dn_instrEn, dn_instr, dn_other,
    output q_read_avail, q_read_instr0, q_read_other0, dn_max, dn_ready
  );

endinterface

`default_nettype wire

// File: rtl/iq_drain_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_drain_arb : thread select FSM, per-thread run counter and yield control
// Rev 1.0
// ----------------------------------------------------------------------------
module iq_drain_arb
  import iq_drain_pkg::*;
#(
  parameter int RUN_LIMIT = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] i_thread_en,
  input  wire logic       i_except,
  input  wire logic       i_except_thread,
  input  wire logic       i_pop,
  input  wire logic       i_avail_zero,
  output logic            o_q_read_thread,
  output logic            o_thd_reg,
  output logic            o_run_ok
);

  localparam int                 c_RUN_W    = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
  localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(RUN_LIMIT - 1);

  drain_state_t       r_state, w_state_nxt;
  logic               r_thread, w_thread_nxt;
  logic               r_thd;
  logic [c_RUN_W-1:0] r_run_cnt, w_run_nxt;
  logic               w_cur_en, w_oth_en, w_switch;

  assign w_cur_en = i_thread_en[r_thread];
  assign w_oth_en = i_thread_en[~r_thread];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SETTLE;
      r_thread  <= 1'b0;
      r_thd     <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_thread  <= w_thread_nxt;
      r_thd     <= r_thread;
      r_run_cnt <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_thread_nxt = r_thread;
    w_run_nxt    = r_run_cnt;
    w_switch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_thread_en) begin
          w_state_nxt  = SETTLE;
          w_thread_nxt = ~i_thread_en[0];
          w_run_nxt    = '0;
        end
      end
      SETTLE: begin
        w_state_nxt = RUN;
        if (!w_cur_en) begin
          if (w_oth_en) w_switch = 1'b1;
          else          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        // A flush of the live thread re-settles so the rewound head re-presents.
        if (i_except && (i_except_thread == r_thd)) begin
          w_state_nxt = SETTLE;
        end else if (!w_cur_en) begin
          if (w_oth_en) w_switch = 1'b1;
          else          w_state_nxt = IDLE;
        end else begin
          if (i_pop)
            w_run_nxt = (r_run_cnt == c_RUN_LAST) ? r_run_cnt : r_run_cnt + c_RUN_W'(1);
          if (w_oth_en && ((i_pop && (r_run_cnt == c_RUN_LAST)) || i_avail_zero))
            w_switch = 1'b1;
        end
      end
      default: w_state_nxt = SETTLE;
    endcase
    if (w_switch) begin
      w_state_nxt  = SETTLE;
      w_thread_nxt = ~r_thread;
      w_run_nxt    = '0;
    end
  end

  assign o_q_read_thread = r_thread;
  assign o_thd_reg       = r_thd;
  assign o_run_ok        = (r_state == RUN);

endmodule

`default_nettype wire

// File: rtl/iq_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_drain : instruction queue read-side controller with pop sizing and
//            a single-entry output register toward rename/dispatch
// Rev 1.0
// ----------------------------------------------------------------------------
module iq_drain
  import iq_drain_pkg::*;
#(
  parameter int RD_SLOTS  = IQ_RD_SLOTS,
  parameter int WIDTH     = IQ_WIDTH,
  parameter int OTHER     = IQ_OTHER,
  parameter int RUN_LIMIT = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  iq_drain_if.master      bus,
  input  wire logic [1:0] thread_en,
  input  wire logic       except,
  input  wire logic       except_thread
);

  logic                      w_q_thread, w_thd, w_run_ok;
  logic                      w_pop, w_flush_cur, w_avail_zero;
  logic [IQ_CNT_W-1:0]       w_cnt;
  logic [RD_SLOTS-1:0]       w_mask;
  logic [RD_SLOTS*WIDTH-1:0] w_lane_instr;
  logic [RD_SLOTS*OTHER-1:0] w_lane_other;

  logic                      r_dn_valid;
  logic                      r_dn_thread;
  logic [RD_SLOTS-1:0]       r_dn_en;
  logic [RD_SLOTS*WIDTH-1:0] r_dn_instr;
  logic [RD_SLOTS*OTHER-1:0] r_dn_other;

  iq_drain_arb #(
    .RUN_LIMIT (RUN_LIMIT)
  ) u_arb (
    .clk             (clk),
    .rst             (rst),
    .i_thread_en     (thread_en),
    .i_except        (except),
    .i_except_thread (except_thread),
    .i_pop           (w_pop),
    .i_avail_zero    (w_avail_zero),
    .o_q_read_thread (w_q_thread),
    .o_thd_reg       (w_thd),
    .o_run_ok        (w_run_ok)
  );

  assign w_cnt        = min3(popcnt(bus.q_read_avail), bus.dn_max, IQ_CNT_W'(RD_SLOTS));
  assign w_mask       = therm(w_cnt);
  assign w_avail_zero = (bus.q_read_avail == '0);
  assign w_flush_cur  = except & (except_thread == w_thd);
  // Avail/head data describe thd_reg, so only pop once the read thread has caught up.
  assign w_pop        = w_run_ok & (w_cnt != '0) & (w_q_thread == w_thd)
                      & (~r_dn_valid | bus.dn_ready) & ~w_flush_cur;

  for (genvar i = 0; i < RD_SLOTS; i++) begin : g_lane
    assign w_lane_instr[i*WIDTH +: WIDTH] = w_mask[i] ? bus.q_read_instr0[i*WIDTH +: WIDTH] : '0;
    assign w_lane_other[i*OTHER +: OTHER] = w_mask[i] ? bus.q_read_other0[i*OTHER +: OTHER] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dn_valid  <= 1'b0;
      r_dn_thread <= 1'b0;
      r_dn_en     <= '0;
      r_dn_instr  <= '0;
      r_dn_other  <= '0;
    end else if (w_pop) begin
      r_dn_valid  <= 1'b1;
      r_dn_thread <= w_thd;
      r_dn_en     <= w_mask;
      r_dn_instr  <= w_lane_instr;
      r_dn_other  <= w_lane_other;
    end else if (bus.dn_ready || (except && (except_thread == r_dn_thread))) begin
      r_dn_valid  <= 1'b0;
    end
  end

  assign bus.q_read_thread  = w_q_thread;
  assign bus.q_read_clkEn   = w_pop;
  assign bus.q_read_instrEn = w_pop ? w_mask : '0;
  assign bus.dn_valid       = r_dn_valid;
  assign bus.dn_thread      = r_dn_thread;
  assign bus.dn_instrEn     = r_dn_en;
  assign bus.dn_instr       = r_dn_instr;
  assign bus.dn_other       = r_dn_other;

endmodule

`default_nettype wire

// File: tb/tb_iq_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_iq_drain : directed self-checking bench for iq_drain
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_iq_drain;
  import iq_drain_pkg::*;

  localparam int c_N = IQ_RD_SLOTS;
  localparam int c_W = IQ_WIDTH;
  localparam int c_O = IQ_OTHER;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  thread_en;
  logic        except, except_thread;
  logic [10:0] av0, av1;
  logic [15:0] base;
  logic        tb_thd;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  iq_drain_if bus();

  iq_drain dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .thread_en     (thread_en),
    .except        (except),
    .except_thread (except_thread)
  );

  function automatic logic [c_N*c_W-1:0] mk_instr(input logic thd, input int n, input logic [15:0] b);
    logic [c_N*c_W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*c_W +: c_W] = c_W'({b, 4'(thd), 4'(i)});
    return v;
  endfunction

  function automatic logic [c_N*c_O-1:0] mk_other(input logic thd, input int n, input logic [15:0] b);
    logic [c_N*c_O-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*c_O +: c_O] = c_O'({4'(thd), 4'(i), b[7:0]});
    return v;
  endfunction

  // Queue model: occupancy and head data follow the previous cycle's read thread.
  always @(posedge clk or negedge rst)
    if (!rst) tb_thd <= 1'b0;
    else      tb_thd <= bus.q_read_thread;

  assign bus.q_read_avail  = tb_thd ? av1 : av0;
  assign bus.q_read_instr0 = mk_instr(tb_thd, c_N, base);
  assign bus.q_read_other0 = mk_other(tb_thd, c_N, base);

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; thread_en = 2'b01; except = 1'b0; except_thread = 1'b0;
    av0 = 11'h01F; av1 = 11'h000; base = 16'hA000;
    bus.dn_max = 4'd11; bus.dn_ready = 1'b1;
    #2;
    chk("rst_thread",  bus.q_read_thread, 0);
    chk("rst_clken",   bus.q_read_clkEn, 0);
    chk("rst_instren", bus.q_read_instrEn, 0);
    chk("rst_dnvalid", bus.dn_valid, 0);
    chk("rst_dninstr", bus.dn_instr, 0);

    // Reset release: one SETTLE bubble, then a 5-lane pop
    @(negedge clk); rst = 1'b1; #1;
    chk("settle_clken", bus.q_read_clkEn, 0);
    step();
    chk("pop5_clken",   bus.q_read_clkEn, 1);
    chk("pop5_instren", bus.q_read_instrEn, 11'h01F);
    step();
    chk("pop5_dnvalid", bus.dn_valid, 1);
    chk("pop5_dnen",    bus.dn_instrEn, 11'h01F);
    chk("pop5_dninstr", bus.dn_instr, mk_instr(1'b0, 5, base));
    chk("pop5_dnother", bus.dn_other, mk_other(1'b0, 5, base));

    // Downstream-limited pop, then dn_max=0 stall with other thread enabled
    av0 = 11'h7FF; bus.dn_max = 4'd3; #1;
    chk("dnmax3_instren", bus.q_read_instrEn, 11'h007);
    step();
    chk("dnmax3_dnen",    bus.dn_instrEn, 11'h007);
    chk("dnmax3_dninstr", bus.dn_instr, mk_instr(1'b0, 3, base));
    bus.dn_max = 4'd0; thread_en = 2'b11; #1;
    chk("stall_clken", bus.q_read_clkEn, 0);
    step(); step();
    chk("stall_thread",  bus.q_read_thread, 0);
    chk("stall_clken2",  bus.q_read_clkEn, 0);
    chk("stall_dnvalid", bus.dn_valid, 0);
    thread_en = 2'b01;

    // Backpressure hold, then zero-bubble pop + handoff
    bus.dn_max = 4'd11; bus.dn_ready = 1'b0; base = 16'h1111; #1;
    chk("bp_first_clken", bus.q_read_clkEn, 1);
    step();
    chk("bp_dnvalid", bus.dn_valid, 1);
    base = 16'h2222; #1;
    chk("bp_clken", bus.q_read_clkEn, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", bus.dn_instr, mk_instr(1'b0, 11, 16'h1111));
    end
    bus.dn_ready = 1'b1; #1;
    chk("handoff_clken", bus.q_read_clkEn, 1);
    step();
    chk("handoff_dnvalid", bus.dn_valid, 1);
    chk("handoff_dninstr", bus.dn_instr, mk_instr(1'b0, 11, 16'h2222));

    // Run-limit yield between two threads
    rst = 1'b0; thread_en = 2'b11; av0 = 11'h7FF; av1 = 11'h003;
    @(negedge clk); rst = 1'b1; #1;
    chk("y_settle", bus.q_read_clkEn, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("y_t0_clken",  bus.q_read_clkEn, 1);
      chk("y_t0_thread", bus.q_read_thread, 0);
    end
    step();
    chk("y_bubble_clken",  bus.q_read_clkEn, 0);
    chk("y_bubble_thread", bus.q_read_thread, 1);
    step();
    chk("y_t1_clken",   bus.q_read_clkEn, 1);
    chk("y_t1_instren", bus.q_read_instrEn, 11'h003);
    step();
    av1 = 11'h000; #1;
    chk("y_t1_dnthread", bus.dn_thread, 1);
    chk("y_t1_dnen",     bus.dn_instrEn, 11'h003);
    chk("y_empty_clken", bus.q_read_clkEn, 0);
    step();
    chk("y_back_thread", bus.q_read_thread, 0);
    chk("y_back_clken",  bus.q_read_clkEn, 0);
    step();
    chk("y_back_pop", bus.q_read_instrEn, 11'h7FF);

    // Exception handling on thread 1
    thread_en = 2'b10; av1 = 11'h00F;
    step();
    chk("x_settle_thread", bus.q_read_thread, 1);
    step();
    chk("x_t1_instren", bus.q_read_instrEn, 11'h00F);
    except = 1'b1; except_thread = 1'b0; #1;
    chk("x_other_pop", bus.q_read_clkEn, 1);
    step();
    except = 1'b1; except_thread = 1'b1; #1;
    chk("x_nopop", bus.q_read_clkEn, 0);
    step();
    except = 1'b0; #1;
    chk("x_dnvalid",  bus.dn_valid, 0);
    chk("x_settle",   bus.q_read_clkEn, 0);
    chk("x_thread",   bus.q_read_thread, 1);
    step();
    chk("x_resume", bus.q_read_instrEn, 11'h00F);
    step();
    bus.dn_ready = 1'b0; except = 1'b1; except_thread = 1'b1;
    step();
    except = 1'b0; #1;
    chk("x_kill_dnvalid", bus.dn_valid, 0);

    // Asynchronous reset mid-bundle
    bus.dn_ready = 1'b1;
    step(); step();
    chk("ar_pre_dnvalid", bus.dn_valid, 1);
    #2; rst = 1'b0; #1;
    chk("ar_dnvalid", bus.dn_valid, 0);
    chk("ar_clken",   bus.q_read_clkEn, 0);
    chk("ar_dnen",    bus.dn_instrEn, 0);
    chk("ar_thread",  bus.q_read_thread, 0);
    thread_en = 2'b01;
    @(negedge clk); rst = 1'b1; #1;
    chk("ar_settle", bus.q_read_clkEn, 0);
    step();
    chk("ar_run_clken",   bus.q_read_clkEn, 1);
    chk("ar_run_instren", bus.q_read_instrEn, 11'h7FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iq_drain.md
Name: iq_drain

Overview:
- Read-side controller for the dual-thread 11-wide instruction suggestion queue.
- Chooses which thread to drain and sizes each pop from the queue's read_avail and the free slots downstream.
- Drives the queue's read_thread, read_clkEn and read_instrEn.
- Holds the popped bundle in a single output register with a valid/ready handshake toward rename/dispatch, and handles per-thread exception flush.

Parameters:
- RD_SLOTS, 11, read lanes per cycle
- WIDTH, 80, instruction bits per lane
- OTHER, `instrQ_width, side-band bits per lane
- RUN_LIMIT, 8, maximum consecutive pops on one thread before yielding

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- q_read_thread  out  1  thread selected for queue read
- q_read_clkEn  out  1  pop strobe to queue
- q_read_instrEn  out  RD_SLOTS  thermometer pop mask
- q_read_avail  in  RD_SLOTS  thermometer occupancy of the previous cycle's q_read_thread
- q_read_instr0  in  RD_SLOTS*WIDTH  head instructions
- q_read_other0  in  RD_SLOTS*OTHER  head side-band
- thread_en  in  2  thread active mask
- except  in  1  flush request
- except_thread  in  1  thread being flushed
- dn_max  in  4  downstream free lanes, 0..11
- dn_ready  in  1  downstream accepts output register
- dn_valid  out  1  output register holds a bundle
- dn_thread  out  1  thread of bundle
- dn_instrEn  out  RD_SLOTS  valid lanes of bundle (thermometer)
- dn_instr  out  RD_SLOTS*WIDTH  bundle instructions
- dn_other  out  RD_SLOTS*OTHER  bundle side-band

Behaviour:
- Queue contract: q_read_avail and q_read_instr0/other0 in cycle N refer to the thread driven on q_read_thread in cycle N-1 (thd_reg). A pop in cycle N consumes those lanes.
- Reset (rst=0) is asynchronous and forces:
  - state=SETTLE, q_read_thread=0, thd_reg=0, run_cnt=0
  - q_read_clkEn=0, q_read_instrEn=0
  - dn_valid=0, dn_thread=0, dn_instrEn=0, dn_instr=0, dn_other=0
- States:
  - IDLE: thread_en==0. No pops. Move to SETTLE when any thread_en bit is set, selecting the lowest enabled thread.
  - SETTLE: one bubble cycle. q_read_thread is already the new thread; q_read_clkEn=0. Next state is RUN.
  - RUN: pop allowed.
- Pop size: cnt = min(popcount(q_read_avail), dn_max, RD_SLOTS). q_read_instrEn = low cnt bits set.
- Pop condition: state==RUN, cnt>0, q_read_thread==thd_reg, and (~dn_valid | dn_ready), with no flush of thd_reg this cycle. q_read_clkEn=1 only on a pop; otherwise q_read_clkEn=0 and instrEn=0.
- On a pop, the output register loads the head lanes masked by instrEn (unused lanes zeroed), dn_thread=thd_reg, dn_valid=1. If there is no pop and dn_ready=1, dn_valid clears.
- Zero-bubble streaming: a pop and a dn_ready handoff in the same cycle both occur.
- run_cnt increments per pop and clears on a thread switch.
- Yield from RUN to the other thread (via SETTLE) when the other thread is enabled and either:
  - cnt==0 because avail==0, or
  - run_cnt reaches RUN_LIMIT-1 on a pop (the pop still happens).
  A dn_max==0 stall does not yield.
- If the current thread's thread_en drops: switch if the other thread is enabled, else go to IDLE.
- except with except_thread==thd_reg:
  - no pop that cycle
  - if dn_thread==except_thread, dn_valid clears next edge
  - go to SETTLE on the same thread, so the reset queue pointers re-present
- except on the other thread: only the dn_valid kill rule applies; pops continue.
- except has priority over pop and yield. Deasserting rst mid-bundle drops the bundle with no replay.
- dn_instr/dn_other hold stable while dn_valid & ~dn_ready.

Decomposition:
- Shared package: IQ_RD_SLOTS=11, IQ_WIDTH=80, `instrQ_width, drain state enum {IDLE,SETTLE,RUN}, thermometer-from-count and min3 functions.
- Natural sub-module iq_drain_arb: the thread FSM, run_cnt and yield logic. It outputs q_read_thread, thd_reg and run_ok. The top level holds the pop sizing and the output register.

Test Plan:
- Reset release, thread_en=01, avail=thermometer 5, dn_max=11, dn_ready=1 -> one SETTLE cycle, then clkEn=1 with instrEn=0x01F and dn_valid=1 next cycle with dn_instrEn=0x01F.
- avail=11 lanes, dn_max=3 -> instrEn=0x007. Then dn_max=0 -> clkEn=0, no yield, thread unchanged.
- dn_ready=0 with dn_valid=1 -> clkEn=0 and dn_instr held stable for 5 cycles. dn_ready=1 -> pop and handoff in the same cycle.
- thread_en=11, thread 0 always avail=11 -> pops 8 cycles, then 1 SETTLE bubble, then thread 1 pops. Thread 1 avail=0 -> immediate switch back to thread 0.
- Pop on thread 1 with except=1, except_thread=1 -> clkEn=0 that cycle, dn_valid (thread 1) clears, SETTLE, then resume thread 1.
- Assert rst=0 asynchronously mid-RUN with dn_valid=1 -> dn_valid=0 and clkEn=0 before the next edge. State returns to SETTLE after release.
